// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage pipeline sequencer: FSM state encodings, control bundle, defaults.
package pipeline_ctrl_pkg;

    localparam int unsigned CANT_BITS_CONTADOR_DEF = 32;
    localparam int unsigned CANT_CICLOS_DRAIN_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_RUN   = 3'b001,
        ST_STEP  = 3'b010,
        ST_DRAIN = 3'b011,
        ST_DONE  = 3'b100
    } estado_t;

    typedef struct packed {
        logic en_pc;
        logic en_if_id;
        logic en_id_ex;
        logic en_ex_mem;
        logic en_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } ctrl_t;

    localparam ctrl_t CTRL_FROZEN = '{default: 1'b0};

    // Every latch advancing, no flush.
    function automatic ctrl_t ctrl_all_enabled();
        ctrl_t c;
        c             = CTRL_FROZEN;
        c.en_pc       = 1'b1;
        c.en_if_id    = 1'b1;
        c.en_id_ex    = 1'b1;
        c.en_ex_mem   = 1'b1;
        c.en_mem_wb   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Up-counter with synchronous clear and optional saturation at all-ones (else wraps).
module contador_saturado #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_saturate,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !(i_saturate && (count_q == {WIDTH{1'b1}}))) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Run/step/drain sequencer for the 5-stage MIPS pipeline with cycle and stall counters.
// Optional stall counter enabled by defining PIPELINE_CTRL_STALL_COUNT_EN.
module pipeline_control_unit #(
    parameter int unsigned CANT_BITS_CONTADOR = pipeline_ctrl_pkg::CANT_BITS_CONTADOR_DEF,
    parameter int unsigned CANT_CICLOS_DRAIN  = pipeline_ctrl_pkg::CANT_CICLOS_DRAIN_DEF
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_run,
    input  logic                          i_step,
    input  logic                          i_halt_detected,
    input  logic                          i_bit_burbuja,
    input  logic                          i_branch_taken,
    input  logic                          i_exception,
    output logic                          o_enable_pc,
    output logic                          o_enable_if_id,
    output logic                          o_enable_id_ex,
    output logic                          o_enable_ex_mem,
    output logic                          o_enable_mem_wb,
    output logic                          o_flush_if_id,
    output logic                          o_flush_id_ex,
    output logic                          o_enable_etapa,
    output logic                          o_halted,
    output logic [2:0]                    o_estado,
    output logic [CANT_BITS_CONTADOR-1:0] o_cycle_count,
    output logic [CANT_BITS_CONTADOR-1:0] o_stall_count
);

    import pipeline_ctrl_pkg::*;

    localparam int unsigned DRAIN_W = $clog2(CANT_CICLOS_DRAIN + 1);

    estado_t             state_q;
    estado_t             state_d;
    logic [DRAIN_W-1:0]  drain_q;
    logic [DRAIN_W-1:0]  drain_d;
    ctrl_t               ctrl;
    logic                advancing;

    assign advancing = (state_q == ST_RUN) || (state_q == ST_STEP);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state: HALT in ID takes priority over leaving RUN/STEP.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = ST_RUN;
                end else if (i_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_W'(CANT_CICLOS_DRAIN);
                end else if (!i_run) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (i_halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_W'(CANT_CICLOS_DRAIN);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q == DRAIN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stage enable/flush decode; responds in the same cycle as the hazard inputs.
    always_comb begin
        ctrl = CTRL_FROZEN;
        case (state_q)
            ST_RUN, ST_STEP: begin
                ctrl = ctrl_all_enabled();
                if (i_exception) begin
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id_ex = 1'b1;
                end else if (i_bit_burbuja) begin
                    // Branch ignored under a bubble; it is re-evaluated once the load resolves.
                    ctrl.en_pc       = 1'b0;
                    ctrl.en_if_id    = 1'b0;
                    ctrl.flush_id_ex = 1'b1;
                end else if (i_branch_taken) begin
                    ctrl.flush_if_id = 1'b1;
                end
            end
            ST_DRAIN: begin
                ctrl             = ctrl_all_enabled();
                ctrl.en_pc       = 1'b0;
                ctrl.en_if_id    = 1'b0;
                ctrl.flush_if_id = 1'b1;
            end
            default: begin
                ctrl = CTRL_FROZEN;
            end
        endcase
    end

    assign o_enable_pc     = ctrl.en_pc;
    assign o_enable_if_id  = ctrl.en_if_id;
    assign o_enable_id_ex  = ctrl.en_id_ex;
    assign o_enable_ex_mem = ctrl.en_ex_mem;
    assign o_enable_mem_wb = ctrl.en_mem_wb;
    assign o_flush_if_id   = ctrl.flush_if_id;
    assign o_flush_id_ex   = ctrl.flush_id_ex;
    assign o_enable_etapa  = ctrl.en_pc | ctrl.en_if_id | ctrl.en_id_ex
                           | ctrl.en_ex_mem | ctrl.en_mem_wb;
    assign o_halted        = (state_q == ST_DONE);
    assign o_estado        = state_q;

    contador_saturado #(
        .WIDTH (CANT_BITS_CONTADOR)
    ) u_cycle_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (o_enable_etapa),
        .i_clear    (1'b0),
        .i_saturate (1'b0),
        .o_count    (o_cycle_count)
    );

`ifdef PIPELINE_CTRL_STALL_COUNT_EN
    logic stall_applied;

    // A bubble only counts when the exception path did not override it.
    assign stall_applied = advancing && i_bit_burbuja && !i_exception;

    contador_saturado #(
        .WIDTH (CANT_BITS_CONTADOR)
    ) u_stall_cnt (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (stall_applied),
        .i_clear    (1'b0),
        .i_saturate (1'b1),
        .o_count    (o_stall_count)
    );
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: hazard decode table, corner sequences, random run.
module tb_pipeline_control_unit;

    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst_n, run, step, halt, bub, br, exc;
    logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex;
    logic          etapa, halted;
    logic [2:0]    estado;
    logic [CW-1:0] cyc_cnt, stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=idle 1=run 2=step 3=drain 4=done
    int            m_mode = 0;
    int            m_left = 0;
    logic [CW-1:0] m_cyc   = '0;
    logic [CW-1:0] m_stall = '0;
    logic [6:0]    m_ctrl;
    logic          m_etapa, m_stall_hit;

    always #5 clk = ~clk;

    pipeline_control_unit dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_run           (run),
        .i_step          (step),
        .i_halt_detected (halt),
        .i_bit_burbuja   (bub),
        .i_branch_taken  (br),
        .i_exception     (exc),
        .o_enable_pc     (en_pc),
        .o_enable_if_id  (en_ifid),
        .o_enable_id_ex  (en_idex),
        .o_enable_ex_mem (en_exmem),
        .o_enable_mem_wb (en_memwb),
        .o_flush_if_id   (fl_ifid),
        .o_flush_id_ex   (fl_idex),
        .o_enable_etapa  (etapa),
        .o_halted        (halted),
        .o_estado        (estado),
        .o_cycle_count   (cyc_cnt),
        .o_stall_count   (stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model's mode and the current hazard inputs.
    task automatic model_outputs();
        m_stall_hit = 1'b0;
        case (m_mode)
            1, 2: begin
                if (exc)      m_ctrl = 7'b1111111;
                else if (bub) begin
                    m_ctrl = 7'b0011101;
                    m_stall_hit = 1'b1;
                end
                else          m_ctrl = {5'b11111, br, 1'b0};
            end
            3:       m_ctrl = 7'b0011110;
            default: m_ctrl = 7'b0000000;
        endcase
        m_etapa = |m_ctrl[6:2];
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_cyc = '0; m_stall = '0;
            return;
        end
        if (m_etapa) m_cyc = m_cyc + 1;
        if (m_stall_hit && m_stall != '1) m_stall = m_stall + 1;
        case (m_mode)
            0: m_mode = run ? 1 : (step ? 2 : 0);
            1: if (halt) begin m_mode = 3; m_left = 4; end else if (!run) m_mode = 0;
            2: if (halt) begin m_mode = 3; m_left = 4; end else m_mode = 0;
            3: begin m_left--; if (m_left == 0) m_mode = 4; end
            default: m_mode = 4;
        endcase
    endtask

    task automatic check_model();
        logic [CW-1:0] exp_stall;
`ifdef PIPELINE_CTRL_STALL_COUNT_EN
        exp_stall = m_stall;
`else
        exp_stall = '0;
`endif
        model_outputs();
        chk("ctrl", {57'd0, en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex},
            {57'd0, m_ctrl});
        chk("state/etapa/halted", {59'd0, estado, etapa, halted},
            {59'd0, 3'(m_mode), m_etapa, (m_mode == 4)});
        chk("cycle_count", 64'(cyc_cnt), 64'(m_cyc));
        chk("stall_count", 64'(stall_cnt), 64'(exp_stall));
    endtask

    task automatic drive(input logic r, input logic ru, input logic st, input logic h,
                         input logic b, input logic brn, input logic e);
        rst_n = r; run = ru; step = st; halt = h; bub = b; br = brn; exc = e;
    endtask

    task automatic tick(input logic r, input logic ru, input logic st, input logic h,
                        input logic b, input logic brn, input logic e);
        drive(r, ru, st, h, b, brn, e);
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct packed {
        logic       exc;
        logic       bub;
        logic       br;
        logic [6:0] ctrl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 7'b1111110};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 7'b0011101};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 7'b0011101};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 7'b1111111};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 7'b1111111};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 7'b1111111};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 7'b1111111};

        drive(1'b0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tick(1'b0, 0, 0, 0, 0, 0, 0);
        chk("reset state", 64'(estado), 64'd0);
        chk("reset cycle_count", 64'(cyc_cnt), 64'd0);

        // Enter RUN, then sweep the hazard table.
        tick(1'b1, 1, 0, 0, 0, 0, 0);
        chk("run entered", 64'(estado), 64'd1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1, 0, 0, tbl[i].bub, tbl[i].br, tbl[i].exc);
            @(negedge clk);
            chk($sformatf("table[%0d]", i),
                {57'd0, en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex},
                {57'd0, tbl[i].ctrl});
            chk($sformatf("table[%0d] etapa", i), 64'(etapa), 64'd1);
            check_model();
            @(posedge clk);
            model_step();
            #1;
        end

        // Three single steps from a clean reset.
        tick(1'b0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 0, 1, 0, 0, 0, 0);
            chk("step state", 64'(estado), 64'd2);
            tick(1'b1, 0, 0, 0, 0, 0, 0);
            chk("step back to idle", 64'(estado), 64'd0);
        end
        chk("step cycle_count", 64'(cyc_cnt), 64'd3);

        // HALT in RUN: four drain cycles then DONE, immune to run.
        tick(1'b1, 1, 0, 0, 0, 0, 0);
        tick(1'b1, 1, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain state", 64'(estado), 64'd3);
            tick(1'b1, 1, 0, 0, 1, 1, 1);
        end
        chk("done halted", 64'(halted), 64'd1);
        chk("done enables", 64'(etapa), 64'd0);
        tick(1'b1, 1, 1, 0, 0, 0, 0);
        tick(1'b1, 1, 1, 0, 0, 0, 0);
        chk("done sticky", 64'(estado), 64'd4);

        // Reset in the middle of DRAIN.
        tick(1'b0, 0, 0, 0, 0, 0, 0);
        tick(1'b1, 1, 0, 0, 0, 0, 0);
        tick(1'b1, 1, 0, 1, 0, 0, 0);
        tick(1'b1, 1, 0, 0, 0, 0, 0);
        chk("drain before reset", 64'(estado), 64'd3);
        tick(1'b0, 1, 0, 0, 0, 0, 0);
        chk("reset in drain state", 64'(estado), 64'd0);
        chk("reset in drain halted", 64'(halted), 64'd0);
        chk("reset in drain counters", 64'({cyc_cnt, stall_cnt}), 64'd0);

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            tick(($urandom_range(99) >= 2),
                 ($urandom_range(99) < 70),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 3),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 25),
                 ($urandom_range(99) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
